// File: rtl/uart_cmd_rx_if.sv
// Command handshake between the UART command receiver and its consumer.
// The receiver drives valid and the payload; the consumer drives ready.
interface uart_cmd_rx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_a,
        output cmd_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_a,
        input  cmd_b,
        output cmd_ready
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART byte receiver feeding a 4-byte command framer (A5, opcode, arg, checksum)
// with a single-entry output slot and one-cycle error pulses.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_cmd_rx_if.master cmd,
    output logic          frame_err,
    output logic          chk_err,
    output logic          overflow
);

    localparam int CNT_W  = 10;
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_BREAK
    } bit_state_t;

    typedef enum logic [1:0] {
        F_HUNT,
        F_OPC,
        F_ARG,
        F_CHK
    } frame_state_t;

    logic             sync1_q;
    logic             rxs_q;
    bit_state_t       bit_state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_stb_q;
    logic [7:0]       byte_q;
    logic             stop_err_q;

    frame_state_t     frame_state_q;
    logic [7:0]       opc_byte_q;
    logic [7:0]       arg_byte_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic             cmd_valid_q;
    logic [2:0]       cmd_opcode_q;
    logic [3:0]       cmd_a_q;
    logic [3:0]       cmd_b_q;
    logic             frame_err_q;
    logic             chk_err_q;
    logic             overflow_q;

    logic             good_frame_d;
    logic             xfer_d;

    // Bit-level receiver: samples mid-bit, emits a one-cycle byte strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            bit_state_q <= B_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_stb_q  <= 1'b0;
            byte_q      <= '0;
            stop_err_q  <= 1'b0;
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            byte_stb_q <= 1'b0;
            stop_err_q <= 1'b0;
            case (bit_state_q)
                B_IDLE: begin
                    bit_cnt_q <= '0;
                    if (!rxs_q) bit_state_q <= B_START;
                end
                B_START: begin
                    if (bit_cnt_q == CNT_W'(HALF - 1)) begin
                        bit_cnt_q   <= '0;
                        bit_idx_q   <= '0;
                        bit_state_q <= rxs_q ? B_IDLE : B_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                B_DATA: begin
                    if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) bit_state_q <= B_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                B_STOP: begin
                    if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        bit_cnt_q <= '0;
                        if (rxs_q) begin
                            byte_stb_q  <= 1'b1;
                            byte_q      <= shift_q;
                            bit_state_q <= B_IDLE;
                        end else begin
                            stop_err_q  <= 1'b1;
                            bit_state_q <= B_BREAK;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                B_BREAK: begin
                    // A low line after a bad stop bit must not look like a new start bit.
                    if (rxs_q) bit_state_q <= B_IDLE;
                end
                default: bit_state_q <= B_IDLE;
            endcase
        end
    end

    always_comb begin
        good_frame_d = byte_stb_q && (frame_state_q == F_CHK) &&
                       (byte_q == (opc_byte_q ^ arg_byte_q));
        xfer_d       = cmd_valid_q && cmd.cmd_ready;
    end

    // Frame decoder and single-entry command slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_state_q <= F_HUNT;
            opc_byte_q    <= '0;
            arg_byte_q    <= '0;
            to_cnt_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_a_q       <= '0;
            cmd_b_q       <= '0;
            frame_err_q   <= 1'b0;
            chk_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_err_q <= stop_err_q;
            chk_err_q   <= 1'b0;
            overflow_q  <= 1'b0;

            if (stop_err_q) begin
                frame_state_q <= F_HUNT;
                to_cnt_q      <= '0;
            end else if (byte_stb_q) begin
                to_cnt_q <= '0;
                case (frame_state_q)
                    F_HUNT: if (byte_q == 8'hA5) frame_state_q <= F_OPC;
                    F_OPC: begin
                        if (byte_q[7:3] == 5'd0) begin
                            opc_byte_q    <= byte_q;
                            frame_state_q <= F_ARG;
                        end else begin
                            frame_err_q   <= 1'b1;
                            frame_state_q <= F_HUNT;
                        end
                    end
                    F_ARG: begin
                        arg_byte_q    <= byte_q;
                        frame_state_q <= F_CHK;
                    end
                    F_CHK: begin
                        if (!good_frame_d) chk_err_q <= 1'b1;
                        frame_state_q <= F_HUNT;
                    end
                    default: frame_state_q <= F_HUNT;
                endcase
            end else if (frame_state_q != F_HUNT && bit_state_q == B_IDLE) begin
                // Inter-byte idle is only counted while no start bit is in progress.
                if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                    frame_state_q <= F_HUNT;
                    to_cnt_q      <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end

            if (good_frame_d) begin
                if (!cmd_valid_q || cmd.cmd_ready) begin
                    cmd_valid_q  <= 1'b1;
                    cmd_opcode_q <= opc_byte_q[2:0];
                    cmd_a_q      <= arg_byte_q[7:4];
                    cmd_b_q      <= arg_byte_q[3:0];
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (xfer_d) begin
                cmd_valid_q <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid  = cmd_valid_q;
    assign cmd.cmd_opcode = cmd_opcode_q;
    assign cmd.cmd_a      = cmd_a_q;
    assign cmd.cmd_b      = cmd_b_q;
    assign frame_err      = frame_err_q;
    assign chk_err        = chk_err_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized bench for uart_cmd_rx: serial stimulus checked against a byte-level
// frame model, plus directed reset, overflow, glitch and timeout scenarios.
module tb_uart_cmd_rx;

    localparam int CPB = 8;
    localparam int TOB = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic frame_err, chk_err, overflow;

    uart_cmd_rx_if cmd_if ();

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .cmd       (cmd_if),
        .frame_err (frame_err),
        .chk_err   (chk_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          stop_cyc = 0;
    int          rise_cyc = -1;
    int          run_len = 0;
    int          last_run = 0;
    int          n_ferr = 0, n_cerr = 0, n_ovf = 0;
    logic [10:0] got_q[$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic        prev_ferr = 1'b0, prev_cerr = 1'b0, prev_ovf = 1'b0;
    logic [10:0] prev_cmd = '0;
    logic [10:0] cur_cmd;

    assign cur_cmd = {cmd_if.cmd_opcode, cmd_if.cmd_a, cmd_if.cmd_b};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0; prev_ready = 1'b0;
            prev_ferr  = 1'b0; prev_cerr  = 1'b0; prev_ovf = 1'b0;
            run_len    = 0;
        end else begin
            if (frame_err) begin n_ferr++; check_eq("frame_err_width", 32'(prev_ferr), 0); end
            if (chk_err)   begin n_cerr++; check_eq("chk_err_width", 32'(prev_cerr), 0); end
            if (overflow)  begin n_ovf++;  check_eq("overflow_width", 32'(prev_ovf), 0); end
            if (prev_valid && !prev_ready && cmd_if.cmd_valid)
                check_eq("hold_stable", 32'(cur_cmd), 32'(prev_cmd));
            if (cmd_if.cmd_valid && !prev_valid) rise_cyc = cyc;
            if (cmd_if.cmd_valid) run_len++;
            else if (prev_valid) begin last_run = run_len; run_len = 0; end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                got_q.push_back(cur_cmd);
                $display("xfer op=%0d a=%0h b=%0h", cur_cmd[10:8], cur_cmd[7:4], cur_cmd[3:0]);
            end
            prev_valid = cmd_if.cmd_valid;
            prev_ready = cmd_if.cmd_ready;
            prev_ferr  = frame_err;
            prev_cerr  = chk_err;
            prev_ovf   = overflow;
            prev_cmd   = cur_cmd;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  fb[$];
    logic [10:0] exp_q[$];
    int          exp_ferr = 0, exp_cerr = 0, exp_ovf = 0;
    bit          hold_mode = 1'b0;
    bit          slot_full = 1'b0;
    logic [10:0] held_cmd = '0;

    function automatic void model_good(input logic [10:0] c);
        if (!hold_mode) exp_q.push_back(c);
        else if (slot_full) exp_ovf++;
        else begin slot_full = 1'b1; held_cmd = c; end
    endfunction

    // fb holds the bytes accepted so far in the current frame.
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] o, a;
        if (fb.size() == 0) begin
            if (b == 8'hA5) fb.push_back(b);
        end else if (fb.size() == 1) begin
            if (b[7:3] == 5'd0) fb.push_back(b);
            else begin exp_ferr++; fb.delete(); end
        end else if (fb.size() == 2) begin
            fb.push_back(b);
        end else begin
            o = fb[1];
            a = fb[2];
            if (b == (o ^ a)) model_good({o[2:0], a});
            else exp_cerr++;
            fb.delete();
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b, input int gap);
        send_byte(b, 1'b1);
        model_byte(b);
        idle(gap);
    endtask

    task automatic tx_stop_err(input logic [7:0] b, input int gap);
        send_byte(b, 1'b0);
        exp_ferr++;
        fb.delete();
        idle(gap);
    endtask

    task automatic compare_all(input string tag);
        int n;
        idle(4);
        check_eq({tag, "/ferr"}, 32'(n_ferr), 32'(exp_ferr));
        check_eq({tag, "/cerr"}, 32'(n_cerr), 32'(exp_cerr));
        check_eq({tag, "/ovf"},  32'(n_ovf),  32'(exp_ovf));
        check_eq({tag, "/ncmd"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "/cmd"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] op, arg, chk;
        int kind;

        cmd_if.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid",  32'(cmd_if.cmd_valid), 0);
        check_eq("rst_cmd",    32'(cur_cmd), 0);
        check_eq("rst_pulses", 32'({frame_err, chk_err, overflow}), 0);
        rst_n = 1'b1;
        idle(5);

        // Basic good frame with latency and pulse width.
        rise_cyc = -1;
        tx(8'hA5, 2); tx(8'h02, 2); tx(8'h3C, 2);
        send_byte(8'h3E, 1'b1); model_byte(8'h3E);
        idle(4);
        check_eq("lat_window", 32'((rise_cyc - stop_cyc >= CPB / 2) && (rise_cyc - stop_cyc <= CPB + 3)), 1);
        check_eq("valid_pulse_len", 32'(last_run), 1);
        compare_all("good_frame");

        // Checksum error followed by a good frame.
        tx(8'hA5, 3); tx(8'h02, 3); tx(8'h3C, 3); tx(8'h3F, 10);
        tx(8'hA5, 3); tx(8'h01, 3); tx(8'h12, 3); tx(8'h13, 10);
        compare_all("chk_then_good");

        // Bad stop bit, then a short low glitch that must be ignored.
        tx_stop_err(8'h55, 20);
        @(negedge clk) rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        compare_all("stop_err_glitch");

        // Inter-byte timeout resyncs silently.
        tx(8'hA5, 2); tx(8'h02, 200);
        fb.delete();
        tx(8'h3C, 2); tx(8'h3E, 10);
        compare_all("timeout");

        // Held command, overflow on second frame, then transfer.
        @(posedge clk); #1 cmd_if.cmd_ready = 1'b0;
        hold_mode = 1'b1;
        tx(8'hA5, 2); tx(8'h01, 2); tx(8'h12, 2); tx(8'h13, 20);
        tx(8'hA5, 2); tx(8'h04, 2); tx(8'h56, 2); tx(8'h52, 10);
        check_eq("ovf_valid_held", 32'(cmd_if.cmd_valid), 1);
        check_eq("ovf_cmd_held", 32'(cur_cmd), 32'(held_cmd));
        @(posedge clk); #1 cmd_if.cmd_ready = 1'b1;
        exp_q.push_back(held_cmd);
        slot_full = 1'b0;
        hold_mode = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("valid_fall", 32'(cmd_if.cmd_valid), 0);
        compare_all("overflow");

        // Asynchronous reset during the data bits of the second byte.
        @(posedge clk); #1 cmd_if.cmd_ready = 1'b0;
        hold_mode = 1'b1;
        tx(8'hA5, 2); tx(8'h01, 2); tx(8'h12, 2); tx(8'h13, 10);
        tx(8'hA5, 2);
        check_eq("pre_rst_valid", 32'(cmd_if.cmd_valid), 1);
        @(negedge clk) rx = 1'b0;
        idle(CPB);
        rx = 1'b1; idle(CPB);
        rx = 1'b0; idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid",  32'(cmd_if.cmd_valid), 0);
        check_eq("midrst_cmd",    32'(cur_cmd), 0);
        check_eq("midrst_pulses", 32'({frame_err, chk_err, overflow}), 0);
        rx = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        fb.delete();
        slot_full = 1'b0;
        hold_mode = 1'b0;
        got_q.delete();
        exp_q.delete();
        idle(5);
        rst_n = 1'b1;
        idle(5);
        tx(8'hA5, 2); tx(8'h03, 2); tx(8'h47, 2); tx(8'h44, 10);
        compare_all("after_reset");

        // Randomized frames and faults against the byte-level model.
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 5));
            op   = 8'($urandom_range(0, 7));
            arg  = 8'($urandom);
            chk  = op ^ arg;
            $display("item %0d kind %0d op %0h arg %0h", it, kind, op, arg);
            case (kind)
                0: begin
                    tx(8'hA5, int'($urandom_range(1, 60))); tx(op, int'($urandom_range(1, 60)));
                    tx(arg, int'($urandom_range(1, 60)));   tx(chk, int'($urandom_range(1, 60)));
                end
                1: begin
                    tx(8'hA5, 5); tx(op, 5); tx(arg, 5);
                    tx(chk ^ 8'($urandom_range(1, 255)), 5);
                end
                2: begin
                    tx(8'hA5, 5); tx(8'($urandom_range(8, 255)), 5);
                end
                3: tx(8'($urandom), int'($urandom_range(1, 60)));
                4: begin
                    tx(8'hA5, 5); tx_stop_err(8'($urandom), 10);
                end
                default: begin
                    tx(8'hA5, 5); tx(op, 220);
                    fb.delete();
                    tx(arg, 5); tx(chk, 5);
                end
            endcase
        end
        compare_all("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per UART bit (10 MHz / 115200); legal range 4..1023.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20: idle bit-periods allowed between bytes of one frame before resync.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial in, idle high, 8N1, LSB first.
REQ-006 SHALL have port cmd_valid  output  1  command available to the FSM.
REQ-007 SHALL have port cmd_ready  input  1  FSM accepts command this cycle.
REQ-008 SHALL have port cmd_opcode  output  3  ALU opcode.
REQ-009 SHALL have port cmd_a  output  4  operand a (upper nibble of ARG byte).
REQ-010 SHALL have port cmd_b  output  4  operand b (lower nibble of ARG byte).
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: bad stop bit or bad opcode byte.
REQ-012 SHALL have port chk_err  output  1  one-cycle pulse: checksum mismatch.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse: good frame dropped, output slot held.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-015 Bit FSM states IDLE, START, DATA, STOP; IDLE->START on rxs=0.
REQ-016 START: after CLKS_PER_BIT/2 cycles (integer division) rxs sampled; 0 -> DATA, 1 -> IDLE (glitch, no error).
REQ-017 DATA: 8 samples, each CLKS_PER_BIT cycles after the previous, LSB first; then STOP after a further CLKS_PER_BIT.
REQ-018 STOP: rxs=1 -> byte strobe for one cycle, go IDLE; rxs=0 -> frame_err pulse, byte discarded, frame FSM -> HUNT, bit FSM waits for rxs=1 before IDLE.
REQ-019 Frame FSM states HUNT, OPC, ARG, CHK; one transition per byte strobe.
REQ-020 HUNT: byte 0xA5 -> OPC; any other byte ignored, no error.
REQ-021 OPC: byte[7:3]=0 -> latch byte[2:0], ARG; otherwise frame_err pulse, HUNT.
REQ-022 ARG: latch byte, CHK.
REQ-023 CHK: byte equals OPC byte XOR ARG byte -> frame good, HUNT; else chk_err pulse, HUNT.
REQ-024 In OPC/ARG/CHK, if no start bit is detected within TIMEOUT_BITS*CLKS_PER_BIT cycles after the previous byte strobe, frame FSM SHALL return to HUNT silently.
REQ-025 Good frame: cmd_valid=1 and cmd_* loaded on the cycle after the CHK byte strobe (latency 1 clock from strobe).
REQ-026 cmd_opcode/cmd_a/cmd_b SHALL be stable while cmd_valid=1 and not transferred; transfer = cmd_valid & cmd_ready.
REQ-027 Transfer without a new good frame the same cycle: cmd_valid -> 0 next cycle.
REQ-028 New good frame while cmd_valid=1 and cmd_ready=0: overflow pulse, new frame dropped, old command kept.
REQ-029 New good frame in the same cycle as a transfer: new command loaded, cmd_valid stays 1, no overflow.
REQ-030 cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-031 Error pulses SHALL be exactly one cycle and SHALL NOT alter cmd_valid or cmd_*.

Reset
REQ-032 rst_n=0 SHALL immediately force: bit FSM IDLE, frame FSM HUNT, counters 0, synchronizer flops 1, cmd_valid 0, cmd_opcode/cmd_a/cmd_b 0, frame_err/chk_err/overflow 0.
REQ-033 Reset mid-byte or mid-frame SHALL discard partial data; after release, reception resumes only at the next falling edge of rxs.

Verification (CLKS_PER_BIT=8, TIMEOUT_BITS=20)
REQ-034 Bytes A5,02,3C,3E, cmd_ready=1 -> one-cycle cmd_valid with opcode=2, a=3, b=C, one cycle after last stop sample; no error pulses.
REQ-035 Bytes A5,02,3C,3F -> chk_err one pulse, cmd_valid stays 0; following A5,01,12,13 -> opcode=1, a=1, b=2.
REQ-036 Byte 0x55 with stop bit driven 0 -> frame_err one pulse; rx low pulse of 3 cycles -> no byte, no error.
REQ-037 cmd_ready=0, frames {A5,01,12,13} then {A5,04,56,52} -> first command held unchanged, overflow one pulse at second frame; cmd_ready=1 -> opcode=1 transfers, cmd_valid falls.
REQ-038 Bytes A5,02 then 200 idle cycles, then 3C,3E -> no command, no error; rst_n low during DATA of byte 2 of a frame -> all outputs 0 at once, next complete frame decoded correctly.
